reg_serial_reader: RTL and testbench
====================================

REG_SERIAL_READER -- requirements
Module: reg_serial_reader

Interface
REQ-001 Parameter WIDTH, default 16, meaning number of bits read out per transfer (legal range 2..32).
REQ-002 The block SHALL have these ports:
- clk, input, 1 bit: single clock, all state updates on posedge.
- rst, input, 1 bit: asynchronous, active-low reset.
- start, input, 1 bit: request to snapshot din and serialize it.
- din, input, WIDTH bits: parallel register value to be read out.
- sout, output, 1 bit: serial data bit, LSB first.
- sout_valid, output, 1 bit: sout carries a valid bit this cycle.
- busy, output, 1 bit: a transfer is in progress.
- done, output, 1 bit: one-cycle pulse marking transfer completion.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low, on port rst.
REQ-004 All outputs SHALL be driven directly from flip-flops, with no combinational path from any input to any output.

Function
REQ-005 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-006 start SHALL be sampled only in IDLE or DONE; in SHIFT it SHALL be ignored and SHALL NOT be queued.
REQ-007 On a clock edge with start=1 in IDLE or DONE, the block SHALL:
- capture din into a WIDTH-bit shift register;
- clear the bit counter to 0;
- enter SHIFT.
REQ-008 din SHALL be sampled only at the accepting edge; later changes to din SHALL NOT affect the transfer.
REQ-009 If start is accepted at edge E, then bit i of the captured value (i = 0..WIDTH-1) SHALL appear on sout with sout_valid=1 in the cycle after edge E+i.
REQ-010 busy SHALL be 1 exactly while the state is SHIFT, i.e. for WIDTH cycles per transfer.
REQ-011 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and increment once per SHIFT cycle.
REQ-012 When the counter reaches WIDTH-1 in SHIFT, the next edge SHALL enter DONE; the counter SHALL never wrap.
REQ-013 In DONE, done SHALL be 1 for exactly one cycle while sout_valid=0 and busy=0.
REQ-014 From DONE, the next edge SHALL enter SHIFT if start=1, otherwise IDLE.
REQ-015 Back-to-back transfers SHALL therefore have exactly one gap cycle, the done cycle.
REQ-016 sout SHALL be 0 whenever sout_valid=0.
REQ-017 done SHALL be 0 in IDLE and SHIFT.

Reset
REQ-018 While rst=0, the block SHALL force, asynchronously:
- state = IDLE;
- shift register = 0;
- counter = 0;
- sout = 0, sout_valid = 0, busy = 0, done = 0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer immediately, with no done pulse and no remaining bits emitted.
REQ-020 The first start SHALL be accepted at the first clock edge after rst deasserts.

Verification
REQ-021 Basic transfer (WIDTH=16): reset, then start=1 for one cycle with din=16'hA5C3 -> sout sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles with sout_valid=1 and busy=1; then done=1 for one cycle; then IDLE.
REQ-022 Input stability: din=16'hFFFF at start, din changed to 16'h0000 one cycle later -> sixteen 1 bits emitted.
REQ-023 Start during transfer: start held high for the entire transfer -> start ignored during SHIFT; second transfer begins right after the done cycle, with exactly one sout_valid=0 gap.
REQ-024 Reset mid-operation: rst=0 asserted during bit 7 -> all outputs 0 immediately, no done pulse; after rst=1, start with din=16'h0001 -> 1 followed by fifteen 0 bits.
REQ-025 Idle behaviour: start=0 for 20 cycles after reset -> sout, sout_valid, busy and done all remain 0.
REQ-026 Minimum width (WIDTH=2): din=2'b10 -> sout 0 then 1, with done in the third cycle after the accepting edge.

Source files
------------

// File: rtl/reg_serial_reader.sv
// Parallel-to-serial register reader: snapshots din on an accepted start and
// emits it LSB first, one bit per cycle, followed by a single done cycle.
module reg_serial_reader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  // Bit 0 goes straight to sout at the accepting edge, so the shift register
  // holds the remaining bits already aligned for the next SHIFT edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state      <= SHIFT;
            shreg      <= din >> 1;
            cnt        <= '0;
            sout       <= din[0];
            sout_valid <= 1'b1;
            busy       <= 1'b1;
          end else begin
            state      <= IDLE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= DONE;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            shreg <= shreg >> 1;
            sout  <= shreg[0];
          end
        end
        default: begin
          state      <= IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_serial_reader.sv
// Directed bench for reg_serial_reader: a 16-bit instance for the main
// transfers and corner cases, plus a 2-bit instance for the minimum width.
module tb_reg_serial_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic        sout, sout_valid, busy, done;
  logic        start2;
  logic [1:0]  din2;
  logic        sout2, sout_valid2, busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_serial_reader #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .sout(sout), .sout_valid(sout_valid), .busy(busy), .done(done)
  );

  reg_serial_reader #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .din(din2),
    .sout(sout2), .sout_valid(sout_valid2), .busy(busy2), .done(done2)
  );

  typedef struct {
    logic [15:0] din_v;
    logic [15:0] din_after;
    logic [15:0] exp_bits;  // expected sout sequence, bit i = i-th serial bit
  } vec_t;

  vec_t vecs[4];

  function automatic logic [3:0] o16();
    return {sout, sout_valid, busy, done};
  endfunction

  function automatic logic [3:0] o2();
    return {sout2, sout_valid2, busy2, done2};
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: {sout,valid,busy,done} got %b want %b", name, act, exp);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  // Checks the 16 data cycles; after bit 0 is seen, drives start/din to new values.
  task automatic shift_check(input string name, input logic [15:0] exp_w,
                             input logic start_after, input logic [15:0] din_after);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("%s bit%0d", name, i), o16(), {exp_w[i], 3'b110});
      if (i == 0) begin
        start = start_after;
        din   = din_after;
      end
    end
  endtask

  initial begin
    // Hand-computed: A5C3 LSB first is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
    vecs[0] = '{16'hA5C3, 16'hA5C3, 16'b1010_0101_1100_0011};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'b1111_1111_1111_1111};
    vecs[2] = '{16'h8000, 16'h7FFF, 16'b1000_0000_0000_0000};
    vecs[3] = '{16'h0001, 16'hFFFE, 16'b0000_0000_0000_0001};

    rst    = 1'b0;
    start  = 1'b0;
    din    = 16'h0000;
    start2 = 1'b0;
    din2   = 2'b00;

    // Reset state
    @(negedge clk);
    chk("reset16", o16(), 4'b0000);
    chk("reset2", o2(), 4'b0000);
    rst = 1'b1;

    // Idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", i), o16(), 4'b0000);
    end

    // Table-driven single transfers
    for (int v = 0; v < 4; v++) begin
      start = 1'b1;
      din   = vecs[v].din_v;
      shift_check($sformatf("vec%0d", v), vecs[v].exp_bits, 1'b0, vecs[v].din_after);
      @(negedge clk);
      chk($sformatf("vec%0d done", v), o16(), 4'b0001);
      @(negedge clk);
      chk($sformatf("vec%0d idle", v), o16(), 4'b0000);
    end

    // start held high: ignored in SHIFT, retriggers from DONE with one gap cycle
    start = 1'b1;
    din   = 16'h1234;
    shift_check("hold1", 16'h1234, 1'b1, 16'h5678);
    @(negedge clk);
    chk("hold1 done", o16(), 4'b0001);
    shift_check("hold2", 16'h5678, 1'b0, 16'h0000);
    @(negedge clk);
    chk("hold2 done", o16(), 4'b0001);
    @(negedge clk);
    chk("hold2 idle", o16(), 4'b0000);

    // Reset during bit 7
    start = 1'b1;
    din   = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("abort bit%0d", i), o16(), 4'b1110);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("abort async", o16(), 4'b0000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort hold%0d", i), o16(), 4'b0000);
    end
    rst   = 1'b1;
    start = 1'b1;
    din   = 16'h0001;
    shift_check("post_rst", 16'h0001, 1'b0, 16'hFFFF);
    @(negedge clk);
    chk("post_rst done", o16(), 4'b0001);
    @(negedge clk);
    chk("post_rst idle", o16(), 4'b0000);

    // Minimum width instance
    start2 = 1'b1;
    din2   = 2'b10;
    @(negedge clk);
    chk("w2 bit0", o2(), 4'b0110);
    start2 = 1'b0;
    din2   = 2'b01;
    @(negedge clk);
    chk("w2 bit1", o2(), 4'b1110);
    @(negedge clk);
    chk("w2 done", o2(), 4'b0001);
    @(negedge clk);
    chk("w2 idle", o2(), 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
